seq_ctrl_unit: RTL and testbench
================================

Name: seq_ctrl_unit

Overview:
Parametrised, clocked successor to the combinational control decoder.
- Owns the decode state register, the previous-instruction latch and the compare-flag register internally.
- Fully implements immediate mode, which the previous generation leaves as a stub.
- Adds an instruction-valid stall, a sticky halt/Ack with restart, and a sticky illegal-opcode flag.
- Sits between the instruction ROM/fetch unit and the ALU, register, data-memory and LFSR datapath.

Parameters:
IW, 9, instruction width; must be >= 9. Fields: class = [IW-1], op = [IW-2:IW-5], arg = [3:2], sub = [3:0].
DW, 8, data/immediate width; must be <= IW-1.
AW, 8, data-memory address width; must be <= IW.
PW, 9, program-counter/branch-target width; must be <= IW.

Ports:
Clk  in  1  clock
Reset_n  in  1  asynchronous active-low reset
InstrValid  in  1  Instruction is valid this cycle; low = stall
Instruction  in  IW  current instruction word
AluFlags  in  3  {Z, EQ, GT} from ALU
Start  in  1  releases HALT
BranchEn  out  1  load PC from BranchTarget
PcSkip  out  1  PC += 2 (skip the target word of an untaken branch)
BranchTarget  out  PW  branch destination
MemAddrCtrl  out  1  1 = MemoryTarget, 0 = mem-reg pointer
MemValueCtrl  out  1  1 = Acc, 0 = mem-reg
MemWrEn  out  1  data-memory write
MemoryTarget  out  AW  direct address
AccLoadEn  out  1  load Acc from ALU
RegLoadEn  out  1  load mem-reg from ALU
AccClr  out  1  clear Acc
RegClr  out  1  clear mem-reg
OPCode  out  3  ALU op (Definitions enum)
ALUInput  out  2  ALU B source: 00 mem-reg, 01 target data, 10 immediate
ImmediateOut  out  DW  immediate
LFSRSetState  out  1  LFSR seed load
LFSRSetTapPtrn  out  1  LFSR tap-pattern load
LFSRShift  out  1  LFSR shift
CmpFlags  out  3  registered {Z, EQ, GT}
Ack  out  1  program done (registered, sticky)
IllegalOp  out  1  sticky illegal-opcode flag
StateOut  out  2  current state, for debug

Behaviour:
- States: REG = 00, TGT = 01, IMM = 10, HALT = 11.
- Registers: state, PrevInstr[IW], CmpFlags, Ack, IllegalOp.
- Reset (asynchronous): state = REG; PrevInstr = 0; CmpFlags = 0; Ack = 0; IllegalOp = 0.
- Output decode is combinational from state, Instruction and PrevInstr.
- All strobes (BranchEn, PcSkip, MemWrEn, Acc/Reg load and clear, LFSR*) are 0 when InstrValid = 0, in HALT, or in reset.
- Defaults: BranchTarget = 0; MemoryTarget = Instruction[AW-1:0]; ImmediateOut = Instruction[DW-1:0]; OPCode = ADD; ALUInput = 00.
- Registers update only when InstrValid = 1, with one exception: HALT exits on Start regardless of InstrValid. On every valid cycle, PrevInstr <= Instruction.
- REG, class = 1 (branch): condition codes in op are 1000 always, 1001 Z, 1010 GT, 1011 GT|EQ, 1100 ~GT&~EQ, 1101 ~GT, 1110 EQ, 1111 ~EQ. All evaluate CmpFlags.
  - Condition true: go to TGT.
  - Condition false: PcSkip = 1, stay in REG.
- REG, class = 0, op = 0000, decoded by sub:
  - 0000 NOP
  - 0001 AccClr
  - 0010 RegClr
  - 0011 LFSRSetState
  - 0100 LFSRSetTapPtrn
  - 0101 LFSRShift
  - 1000 CMP: CmpFlags <= AluFlags at the clock edge
  - 1100 and 1101: go to TGT
  - 1110: MemAddrCtrl = 0, MemValueCtrl = 1, MemWrEn = 1
  - 1111: Ack <= 1, go to HALT
  - Any other sub: IllegalOp <= 1, treated as NOP.
- REG, class = 0, op 0001..1000 (math), decoded by arg: 00 executes now with ALUInput = 00; 01 goes to TGT; 10 goes to IMM; 11 sets IllegalOp.
- Math op map:
  - 0001 ADD → Acc
  - 0010 SUB → Acc
  - 0011 ADD → mem-reg (RegLoadEn)
  - 0101 AND, 0110 OR, 0111 XOR, 1000 XORA → Acc
  - 0100 and 1001..1111: IllegalOp.
- TGT (current word is an operand), always returns to REG:
  - PrevInstr class = 1: BranchEn = 1; BranchTarget = Instruction[PW-1:0].
  - Otherwise: MemoryTarget = Instruction[AW-1:0]; MemAddrCtrl = 1; ALUInput = 01.
  - Prev sub 1100: MemValueCtrl = 1, MemWrEn = 1.
  - Prev sub 1101: MemValueCtrl = 0, MemWrEn = 1.
  - Prev math op: use the math map.
- IMM: ALUInput = 10; ImmediateOut = Instruction[DW-1:0]; math map from PrevInstr; always returns to REG.
- HALT: Ack held at 1. On Start: Ack <= 0, state <= REG.
- Stall in TGT/IMM: state and PrevInstr hold; the operand is consumed on the next valid cycle.
- Reset mid-TGT/IMM: returns to REG; the pending operand is discarded.
- CMP followed immediately by a branch sees the updated flags (one-cycle register latency).

Test Plan:
- Reset_n = 0 while in TGT after ADD-target → StateOut = 00, Ack = 0, CmpFlags = 000; no strobes during reset.
- AluFlags = 001, CMP, then branch GT 0x1A0, then word 0x055 → BranchEn = 1 and BranchTarget = 0x055 in cycle 3. Repeat with AluFlags = 010 → PcSkip = 1 in cycle 2, no TGT.
- Instr 0x018 (ADD imm), then 0x07F → cycle 2: ALUInput = 10, ImmediateOut = 0x7F, OPCode = ADD, AccLoadEn = 1.
- Instr 0x00C, InstrValid low for 3 cycles, then 0x042 valid → MemWrEn only on the valid cycle; MemoryTarget = 0x42, MemValueCtrl = 1.
- Instr 0x00F → Ack = 1 next cycle and held through 5 further cycles; Start pulse → Ack = 0, state REG.
- Instr 0x040 (op 0100) → IllegalOp = 1, sticky until Reset_n; no strobes asserted.

Source files
------------

// File: rtl/seq_ctrl_unit.sv
// seq_ctrl_unit
// Clocked sequencing control unit sitting between the instruction fetch path
// and the ALU / register / data-memory / LFSR datapath. It keeps its own decode
// state, a copy of the previous instruction word (so operand words in TGT/IMM
// can be interpreted) and the compare-flag register. It also provides a sticky
// halt/Ack handshake with restart and a sticky illegal-opcode flag.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   InstrValid          instruction word valid; low stalls all state
//   Instruction[IW]     current instruction or operand word
//   AluFlags[3]         {Z, EQ, GT} from the ALU, captured by CMP
//   Start               releases HALT
//   BranchEn, PcSkip, BranchTarget          program-counter control
//   MemAddrCtrl, MemValueCtrl, MemWrEn,
//   MemoryTarget                            data-memory control
//   AccLoadEn, RegLoadEn, AccClr, RegClr    accumulator / mem-reg control
//   OPCode, ALUInput, ImmediateOut          ALU operation and B-source select
//   LFSRSetState, LFSRSetTapPtrn, LFSRShift LFSR control
//   CmpFlags, Ack, IllegalOp, StateOut      status / debug
module seq_ctrl_unit #(
  parameter int IW = 9,
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int PW = 9
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          InstrValid,
  input  logic [IW-1:0] Instruction,
  input  logic [2:0]    AluFlags,
  input  logic          Start,
  output logic          BranchEn,
  output logic          PcSkip,
  output logic [PW-1:0] BranchTarget,
  output logic          MemAddrCtrl,
  output logic          MemValueCtrl,
  output logic          MemWrEn,
  output logic [AW-1:0] MemoryTarget,
  output logic          AccLoadEn,
  output logic          RegLoadEn,
  output logic          AccClr,
  output logic          RegClr,
  output logic [2:0]    OPCode,
  output logic [1:0]    ALUInput,
  output logic [DW-1:0] ImmediateOut,
  output logic          LFSRSetState,
  output logic          LFSRSetTapPtrn,
  output logic          LFSRShift,
  output logic [2:0]    CmpFlags,
  output logic          Ack,
  output logic          IllegalOp,
  output logic [1:0]    StateOut
);

  typedef enum logic [1:0] {REG = 2'b00, TGT = 2'b01, IMM = 2'b10, HALT = 2'b11} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4, OP_XORA = 3'd5
  } aluop_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] opc;
    logic       accLd;
    logic       regLd;
  } math_t;

  state_t        state, nextState;
  logic [IW-1:0] prevInstr;
  math_t         curMath, prevMath;
  logic          setIllegal, setAck, doCmp, strobeEn;
  logic          brEn, skip, wrEn, accLd, regLd, accClr, regClr, lfsrSt, lfsrTap, lfsrSh;

  // Field views of the current and previous instruction words
  logic       curClass, prevClass;
  logic [3:0] curOp, prevOp, curSub, prevSub;
  logic [1:0] curArg;

  assign curClass  = Instruction[IW-1];
  assign curOp     = Instruction[IW-2:IW-5];
  assign curArg    = Instruction[3:2];
  assign curSub    = Instruction[3:0];
  assign prevClass = prevInstr[IW-1];
  assign prevOp    = prevInstr[IW-2:IW-5];
  assign prevSub   = prevInstr[3:0];

  // Math op map shared by REG (execute now), TGT and IMM; legal=0 marks holes
  function automatic math_t mathDecode(input logic [3:0] op);
    math_t m;
    m = '{legal: 1'b1, opc: OP_ADD, accLd: 1'b1, regLd: 1'b0};
    case (op)
      4'b0001: m.opc = OP_ADD;
      4'b0010: m.opc = OP_SUB;
      4'b0011: begin m.opc = OP_ADD; m.accLd = 1'b0; m.regLd = 1'b1; end
      4'b0101: m.opc = OP_AND;
      4'b0110: m.opc = OP_OR;
      4'b0111: m.opc = OP_XOR;
      4'b1000: m.opc = OP_XORA;
      default: begin m.legal = 1'b0; m.accLd = 1'b0; end
    endcase
    return m;
  endfunction

  // Branch conditions evaluate the registered flags {Z, EQ, GT}
  function automatic logic branchTaken(input logic [2:0] cond, input logic [2:0] f);
    logic z, eq, gt;
    {z, eq, gt} = f;
    case (cond)
      3'b000:  return 1'b1;
      3'b001:  return z;
      3'b010:  return gt;
      3'b011:  return gt | eq;
      3'b100:  return ~gt & ~eq;
      3'b101:  return ~gt;
      3'b110:  return eq;
      default: return ~eq;
    endcase
  endfunction

  // Combinational decode: raw strobes and next state come from state, the
  // current word and the latched previous word; strobes are gated afterwards
  always_comb begin
    curMath      = mathDecode(curOp);
    prevMath     = mathDecode(prevOp);
    nextState    = state;
    setIllegal   = 1'b0;
    setAck       = 1'b0;
    doCmp        = 1'b0;
    brEn = 1'b0; skip = 1'b0; wrEn = 1'b0; accLd = 1'b0; regLd = 1'b0;
    accClr = 1'b0; regClr = 1'b0; lfsrSt = 1'b0; lfsrTap = 1'b0; lfsrSh = 1'b0;
    BranchTarget = '0;
    MemoryTarget = Instruction[AW-1:0];
    ImmediateOut = Instruction[DW-1:0];
    OPCode       = OP_ADD;
    ALUInput     = 2'b00;
    MemAddrCtrl  = 1'b0;
    MemValueCtrl = 1'b0;
    case (state)
      REG: begin
        if (curClass) begin
          // Only op[3]=1 encodes a condition; the lower half is unused
          if (!curOp[3])
            setIllegal = 1'b1;
          else if (branchTaken(curOp[2:0], CmpFlags))
            nextState = TGT;
          else
            skip = 1'b1;
        end else if (curOp == 4'b0000) begin
          case (curSub)
            4'b0000: ;
            4'b0001: accClr  = 1'b1;
            4'b0010: regClr  = 1'b1;
            4'b0011: lfsrSt  = 1'b1;
            4'b0100: lfsrTap = 1'b1;
            4'b0101: lfsrSh  = 1'b1;
            4'b1000: doCmp   = 1'b1;
            4'b1100, 4'b1101: nextState = TGT;
            4'b1110: begin MemValueCtrl = 1'b1; wrEn = 1'b1; end
            4'b1111: begin setAck = 1'b1; nextState = HALT; end
            default: setIllegal = 1'b1;
          endcase
        end else if (!curMath.legal) begin
          setIllegal = 1'b1;
        end else begin
          case (curArg)
            2'b00: begin
              OPCode = curMath.opc;
              accLd  = curMath.accLd;
              regLd  = curMath.regLd;
            end
            2'b01:   nextState = TGT;
            2'b10:   nextState = IMM;
            default: setIllegal = 1'b1;
          endcase
        end
      end
      TGT: begin
        nextState = REG;
        if (prevClass) begin
          brEn         = 1'b1;
          BranchTarget = Instruction[PW-1:0];
        end else begin
          MemAddrCtrl = 1'b1;
          ALUInput    = 2'b01;
          if (prevOp == 4'b0000) begin
            if (prevSub == 4'b1100) begin
              MemValueCtrl = 1'b1;
              wrEn         = 1'b1;
            end else if (prevSub == 4'b1101) begin
              wrEn = 1'b1;
            end
          end else begin
            OPCode = prevMath.opc;
            accLd  = prevMath.accLd;
            regLd  = prevMath.regLd;
          end
        end
      end
      IMM: begin
        nextState = REG;
        ALUInput  = 2'b10;
        OPCode    = prevMath.opc;
        accLd     = prevMath.accLd;
        regLd     = prevMath.regLd;
      end
      default: begin
        if (Start) nextState = REG;
      end
    endcase
  end

  // Strobes only fire on a valid word, outside HALT and outside reset
  assign strobeEn       = InstrValid && Reset_n && (state != HALT);
  assign BranchEn       = strobeEn & brEn;
  assign PcSkip         = strobeEn & skip;
  assign MemWrEn        = strobeEn & wrEn;
  assign AccLoadEn      = strobeEn & accLd;
  assign RegLoadEn      = strobeEn & regLd;
  assign AccClr         = strobeEn & accClr;
  assign RegClr         = strobeEn & regClr;
  assign LFSRSetState   = strobeEn & lfsrSt;
  assign LFSRSetTapPtrn = strobeEn & lfsrTap;
  assign LFSRShift      = strobeEn & lfsrSh;
  assign StateOut       = state;

  // State and status registers; everything waits for a valid word except the
  // HALT exit, which follows Start even while the fetch side is stalled
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= REG;
      prevInstr <= '0;
      CmpFlags  <= 3'b000;
      Ack       <= 1'b0;
      IllegalOp <= 1'b0;
    end else if (state == HALT) begin
      if (Start) begin
        state <= REG;
        Ack   <= 1'b0;
      end
      if (InstrValid) prevInstr <= Instruction;
    end else if (InstrValid) begin
      state     <= nextState;
      prevInstr <= Instruction;
      if (doCmp)      CmpFlags  <= AluFlags;
      if (setIllegal) IllegalOp <= 1'b1;
      if (setAck)     Ack       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// tb_seq_ctrl_unit
// Directed-vector bench for seq_ctrl_unit. The driver applies one vector per
// cycle just after the rising edge and pushes the hand-computed expectation for
// that cycle into a queue; a monitor on the falling edge pops and compares.
module tb_seq_ctrl_unit;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       InstrValid = 1'b0;
  logic [8:0] Instruction = '0;
  logic [2:0] AluFlags = '0;
  logic       Start = 1'b0;
  logic       BranchEn, PcSkip, MemAddrCtrl, MemValueCtrl, MemWrEn;
  logic       AccLoadEn, RegLoadEn, AccClr, RegClr;
  logic       LFSRSetState, LFSRSetTapPtrn, LFSRShift, Ack, IllegalOp;
  logic [8:0] BranchTarget;
  logic [7:0] MemoryTarget, ImmediateOut;
  logic [2:0] OPCode, CmpFlags;
  logic [1:0] ALUInput, StateOut;

  int compared = 0;
  int mismatched = 0;

  // Strobe vector bit positions
  localparam logic [9:0] S_NONE = 10'h000, S_BR = 10'h200, S_SKIP = 10'h100,
                         S_WR = 10'h080, S_ACCLD = 10'h040, S_REGLD = 10'h020,
                         S_ACCCLR = 10'h010;

  typedef struct {
    logic [1:0] st;
    logic [9:0] strb;
    logic       ack;
    logic       ill;
    logic [2:0] cmp;
    logic       chkAux;
    logic [8:0] bt;
    logic [7:0] mt;
    logic [7:0] imm;
    logic [2:0] opc;
    logic [1:0] alui;
    logic       mac;
    logic       mvc;
  } exp_t;

  exp_t expQ[$];

  seq_ctrl_unit #(.IW(9), .DW(8), .AW(8), .PW(9)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InstrValid(InstrValid), .Instruction(Instruction),
    .AluFlags(AluFlags), .Start(Start), .BranchEn(BranchEn), .PcSkip(PcSkip),
    .BranchTarget(BranchTarget), .MemAddrCtrl(MemAddrCtrl), .MemValueCtrl(MemValueCtrl),
    .MemWrEn(MemWrEn), .MemoryTarget(MemoryTarget), .AccLoadEn(AccLoadEn),
    .RegLoadEn(RegLoadEn), .AccClr(AccClr), .RegClr(RegClr), .OPCode(OPCode),
    .ALUInput(ALUInput), .ImmediateOut(ImmediateOut), .LFSRSetState(LFSRSetState),
    .LFSRSetTapPtrn(LFSRSetTapPtrn), .LFSRShift(LFSRShift), .CmpFlags(CmpFlags),
    .Ack(Ack), .IllegalOp(IllegalOp), .StateOut(StateOut)
  );

  // Free-running clock, 10 time-unit period
  always #5 Clk = ~Clk;

  function automatic exp_t eb(input logic [1:0] st, input logic [9:0] strb,
                              input logic ack, input logic ill, input logic [2:0] cmp);
    exp_t e;
    e = '{st: st, strb: strb, ack: ack, ill: ill, cmp: cmp, chkAux: 1'b0,
          bt: '0, mt: '0, imm: '0, opc: '0, alui: '0, mac: 1'b0, mvc: 1'b0};
    return e;
  endfunction

  function automatic exp_t ea(input exp_t base, input logic [8:0] bt, input logic [7:0] mt,
                              input logic [7:0] imm, input logic [2:0] opc,
                              input logic [1:0] alui, input logic mac, input logic mvc);
    exp_t e;
    e = base;
    e.chkAux = 1'b1;
    e.bt = bt; e.mt = mt; e.imm = imm; e.opc = opc; e.alui = alui; e.mac = mac; e.mvc = mvc;
    return e;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("StateOut", 32'(StateOut), 32'(e.st));
    checkField("strobes", 32'({BranchEn, PcSkip, MemWrEn, AccLoadEn, RegLoadEn, AccClr,
                               RegClr, LFSRSetState, LFSRSetTapPtrn, LFSRShift}), 32'(e.strb));
    checkField("Ack", 32'(Ack), 32'(e.ack));
    checkField("IllegalOp", 32'(IllegalOp), 32'(e.ill));
    checkField("CmpFlags", 32'(CmpFlags), 32'(e.cmp));
    if (e.chkAux) begin
      checkField("BranchTarget", 32'(BranchTarget), 32'(e.bt));
      checkField("MemoryTarget", 32'(MemoryTarget), 32'(e.mt));
      checkField("ImmediateOut", 32'(ImmediateOut), 32'(e.imm));
      checkField("OPCode", 32'(OPCode), 32'(e.opc));
      checkField("ALUInput", 32'(ALUInput), 32'(e.alui));
      checkField("MemAddrCtrl", 32'(MemAddrCtrl), 32'(e.mac));
      checkField("MemValueCtrl", 32'(MemValueCtrl), 32'(e.mvc));
    end
  endtask

  // One vector per cycle, applied just after the rising edge
  task automatic applyStimulus(input logic rn, input logic v, input logic [8:0] ins,
                               input logic [2:0] fl, input logic st, input exp_t e);
    @(posedge Clk);
    #1;
    Reset_n     = rn;
    InstrValid  = v;
    Instruction = ins;
    AluFlags    = fl;
    Start       = st;
    expQ.push_back(e);
  endtask

  // Monitor: compares on the falling edge whenever an expectation is pending
  always @(negedge Clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario; states 0=REG 1=TGT 2=IMM 3=HALT
  initial begin
    // Reset held with a valid AccClr word: no strobes, reset values
    applyStimulus(0, 1, 9'h001, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    applyStimulus(1, 0, 9'h000, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    // ADD-target, then reset while in TGT; the operand is discarded
    applyStimulus(1, 1, 9'h014, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    applyStimulus(0, 1, 9'h033, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    applyStimulus(1, 1, 9'h001, 3'b000, 0, eb(2'd0, S_ACCCLR, 0, 0, 3'b000));
    // CMP with GT, branch GT taken, operand word is the target
    applyStimulus(1, 1, 9'h008, 3'b001, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    applyStimulus(1, 1, 9'h1A0, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b001));
    applyStimulus(1, 1, 9'h055, 3'b000, 0,
                  ea(eb(2'd1, S_BR, 0, 0, 3'b001), 9'h055, 8'h55, 8'h55, 3'd0, 2'b00, 0, 0));
    // CMP with EQ only, branch GT not taken: skip, stay in REG
    applyStimulus(1, 1, 9'h008, 3'b010, 0, eb(2'd0, S_NONE, 0, 0, 3'b001));
    applyStimulus(1, 1, 9'h1A0, 3'b000, 0, eb(2'd0, S_SKIP, 0, 0, 3'b010));
    applyStimulus(1, 1, 9'h000, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b010));
    // ADD immediate
    applyStimulus(1, 1, 9'h018, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b010));
    applyStimulus(1, 1, 9'h07F, 3'b000, 0,
                  ea(eb(2'd2, S_ACCLD, 0, 0, 3'b010), 9'h000, 8'h7F, 8'h7F, 3'd0, 2'b10, 0, 0));
    // Store-Acc-to-target with a three-cycle stall before the operand
    applyStimulus(1, 1, 9'h00C, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b010));
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 9'h042, 3'b000, 0, eb(2'd1, S_NONE, 0, 0, 3'b010));
    applyStimulus(1, 1, 9'h042, 3'b000, 0,
                  ea(eb(2'd1, S_WR, 0, 0, 3'b010), 9'h000, 8'h42, 8'h42, 3'd0, 2'b01, 1, 1));
    applyStimulus(1, 1, 9'h000, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b010));
    // Halt: Ack sticky for six cycles, strobes suppressed, Start restarts
    applyStimulus(1, 1, 9'h00F, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b010));
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1, 9'h001, 3'b000, 0, eb(2'd3, S_NONE, 1, 0, 3'b010));
    applyStimulus(1, 0, 9'h000, 3'b000, 1, eb(2'd3, S_NONE, 1, 0, 3'b010));
    applyStimulus(1, 1, 9'h001, 3'b000, 0, eb(2'd0, S_ACCCLR, 0, 0, 3'b010));
    // Execute-now math: ADD into mem-reg, SUB into Acc
    applyStimulus(1, 1, 9'h030, 3'b000, 0,
                  ea(eb(2'd0, S_REGLD, 0, 0, 3'b010), 9'h000, 8'h30, 8'h30, 3'd0, 2'b00, 0, 0));
    applyStimulus(1, 1, 9'h020, 3'b000, 0,
                  ea(eb(2'd0, S_ACCLD, 0, 0, 3'b010), 9'h000, 8'h20, 8'h20, 3'd1, 2'b00, 0, 0));
    // Illegal op 0100: flag sticks until reset, no strobes on that word
    applyStimulus(1, 1, 9'h040, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b010));
    applyStimulus(1, 1, 9'h001, 3'b000, 0, eb(2'd0, S_ACCCLR, 0, 1, 3'b010));
    applyStimulus(1, 1, 9'h000, 3'b000, 0, eb(2'd0, S_NONE, 0, 1, 3'b010));
    applyStimulus(0, 1, 9'h000, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    applyStimulus(1, 0, 9'h000, 3'b000, 0, eb(2'd0, S_NONE, 0, 0, 3'b000));
    repeat (3) @(posedge Clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: actual=%0d pending required=0 pending", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
